// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: frame geometry,
// FSM state encodings, a debug snapshot struct and the bit-reversal helper.
package fft_pkg;

  localparam int DBW = 4;
  localparam int CBW = 3;
  localparam int N   = 1 << CBW;

  typedef enum logic {WR_SYNC, WR_FILL} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

  typedef struct packed {
    wr_state_t wr_state;
    rd_state_t rd_state;
    logic      wb;
  } fft_dbg_t;

  // Reverses the low cbw bits of value; bits at and above cbw come back as 0.
  function automatic logic [15:0] bitrev(input logic [15:0] value, input int cbw);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < cbw) r[cbw-1-i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port. The read
// register clears on reset so the downstream output starts at zero.
module sdp_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order using a
// ping-pong memory: one bank fills while the other drains.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int DBW = fft_pkg::DBW,
  parameter int CBW = fft_pkg::CBW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*DBW-1:0] din,
  input  logic             din_vld,
  input  logic             din_sof,
  output logic [2*DBW-1:0] dout,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic             sof_err
);

  localparam int NPTS = 1 << CBW;

  // Valid semantics: no ready on either side. din is consumed in every cycle
  // din_vld is high; dout_vld marks a fresh sample each cycle and never stalls.

  wr_state_t      wr_state, wr_state_n;
  rd_state_t      rd_state, rd_state_n;
  logic [CBW-1:0] wcnt, wcnt_n, rcnt, rcnt_n, widx;
  logic           wb, wb_n;
  logic           we, re, trig, err_n;
  logic [15:0]    rev;
  fft_dbg_t       dbg;

  assign rev = bitrev(16'(wcnt), CBW);
  assign dbg = '{wr_state: wr_state, rd_state: rd_state, wb: wb};

  always_comb begin
    wr_state_n = wr_state;
    wcnt_n     = wcnt;
    wb_n       = wb;
    we         = 1'b0;
    widx       = rev[CBW-1:0];
    trig       = 1'b0;
    err_n      = 1'b0;
    case (wr_state)
      WR_SYNC: begin
        if (din_vld && din_sof) begin
          we         = 1'b1;
          widx       = '0;
          wcnt_n     = CBW'(1);
          wr_state_n = WR_FILL;
        end
      end
      WR_FILL: begin
        if (din_vld) begin
          we = 1'b1;
          if (din_sof) begin
            // Restart in the same bank; the partial frame is simply overwritten.
            err_n  = (wcnt != '0);
            widx   = '0;
            wcnt_n = CBW'(1);
          end else if (wcnt == CBW'(NPTS - 1)) begin
            wb_n       = ~wb;
            wcnt_n     = '0;
            trig       = 1'b1;
            wr_state_n = WR_SYNC;
          end else begin
            wcnt_n = wcnt + CBW'(1);
          end
        end
      end
      default: wr_state_n = WR_SYNC;
    endcase
  end

  // The drain always reads !wb: a trigger can only coincide with the final
  // drain read, so wb never flips under an in-progress drain.
  always_comb begin
    rd_state_n = rd_state;
    rcnt_n     = rcnt;
    re         = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (trig) begin
          rd_state_n = RD_DRAIN;
          rcnt_n     = '0;
        end
      end
      RD_DRAIN: begin
        re = 1'b1;
        if (rcnt == CBW'(NPTS - 1)) begin
          rcnt_n     = '0;
          rd_state_n = trig ? RD_DRAIN : RD_IDLE;
        end else begin
          rcnt_n = rcnt + CBW'(1);
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_SYNC;
      rd_state <= RD_IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      wb       <= 1'b0;
      dout_vld <= 1'b0;
      dout_sof <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      rd_state <= rd_state_n;
      wcnt     <= wcnt_n;
      rcnt     <= rcnt_n;
      wb       <= wb_n;
      dout_vld <= re;
      dout_sof <= re && (rcnt == '0);
      sof_err  <= err_n;
    end
  end

  sdp_ram #(
    .AW(CBW + 1),
    .DW(2 * DBW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr({wb, widx}),
    .wdata(din),
    .re   (re),
    .raddr({~wb, rcnt}),
    .rdata(dout)
  );

endmodule

// File: tb/tb_fft_reorder.sv
// Directed/randomized bench for fft_reorder: frames go in bit-reversed order
// and a cycle-stamped expected queue predicts every natural-order output.
module tb_fft_reorder;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic       din_sof;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_sof;
  logic       sof_err;

  fft_reorder #(.DBW(4), .CBW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .din_sof (din_sof),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_sof(dout_sof),
    .sof_err (sof_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  // entry = {sof, data[7:0], cycle[31:0]}
  logic [40:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int err_cyc = -1;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int tb_rev(input int v);
    int r = 0;
    for (int b = 0; b < 3; b++) r = r + (((v / (1 << b)) % 2) * (1 << (2 - b)));
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [40:0] e;
      check("sof_err", 64'(sof_err), 64'(cyc == err_cyc));
      if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
        e = exp_q.pop_front();
        check("dout_vld", 64'(dout_vld), 64'd1);
        check("dout", 64'(dout), 64'(e[39:32]));
        check("dout_sof", 64'(dout_sof), 64'(e[40]));
      end else begin
        check("dout_vld_idle", 64'(dout_vld), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit s, input logic [7:0] d, output int c);
    din_vld = v;
    din_sof = s;
    din     = d;
    c       = cyc;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    din_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), c);
  endtask

  // ramp: index i carries re = im = bitrev(i) + base; otherwise random data.
  task automatic send_frame(input bit gap, input bit ramp, input logic [3:0] base, output int t);
    logic [7:0] s[8];
    logic [3:0] v;
    int c;
    for (int i = 0; i < 8; i++) begin
      v    = 4'(tb_rev(i)) + base;
      s[i] = ramp ? {v, v} : 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, s[i], c);
      if (i == 7) t = c;
      else if (gap) idle(1);
    end
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 0, s[tb_rev(k)], 32'(t + 2 + k)});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, c;
    rst = 1'b1; din = '0; din_vld = 1'b0; din_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dout_vld", 64'(dout_vld), 64'd0);
    check("rst_dout_sof", 64'(dout_sof), 64'd0);
    check("rst_sof_err", 64'(sof_err), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // single ramp frame
    send_frame(1'b0, 1'b1, 4'd0, t);
    idle(12);

    // back-to-back ramp frames 0..7 then 8..15
    send_frame(1'b0, 1'b1, 4'd0, t);
    send_frame(1'b0, 1'b1, 4'd8, t);
    idle(20);

    // din_vld gaps, random data
    send_frame(1'b1, 1'b0, 4'd0, t);
    idle(12);

    // early sof after three samples
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 8'($urandom_range(0, 255)), c);
    err_cyc = cyc + 1;
    send_frame(1'b0, 1'b0, 4'd0, t);
    idle(12);

    // pre-sync garbage then a valid frame
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), c);
    send_frame(1'b0, 1'b0, 4'd0, t);
    idle(12);

    // reset during the drain, while bin 3 is on the output
    send_frame(1'b0, 1'b0, 4'd0, t);
    idle(4);
    rst = 1'b1;
    idle(1);
    exp_q.delete();
    check("mid_rst_dout_vld", 64'(dout_vld), 64'd0);
    check("mid_rst_dout", 64'(dout), 64'd0);
    idle(1);
    rst = 1'b0;
    idle(12);
    send_frame(1'b0, 1'b1, 4'd3, t);
    idle(14);

    // random back-to-back burst
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0, 4'd0, t);
    idle(30);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
